// File: rtl/dma_multi.sv
`default_nettype none
// ============================================================================
// Module   : dma_multi
// Purpose  : Multi-channel DMA engine. NUM_CH = 2**CH_BITS channels, each
//            with its own register window, share one ROM/SRAM bus port.
//            Busy channels are serviced one element at a time in round-robin
//            order. Supports COPY, RESET (0x00), SET (0xFF) and FILL, in
//            ascending or descending direction, in byte or word mode.
// Config   : DMA_FILL_EN - when defined, opcode 3 (FILL) and the fill
//            registers A/B are implemented. When undefined, A/B read 0x00,
//            ignore writes, and opcode 3 completes immediately with no bus
//            access.
// Ports    : clkin, reset_n (sync, active low)
//            enable, reg_addr, reg_data_in, reg_data_out, reg_oe_falling,
//            reg_we_rising          - MCU register bus
//            loop_enable, irq       - status outputs
//            BUS_RDY, BUS_RRQ, BUS_WRQ, ROM_ADDR, ROM_DATA_OUT,
//            ROM_WORD_ENABLE, ROM_DATA_IN - memory arbiter port
// Revision : 1.0 - initial release
// ============================================================================
module dma_multi #(
    parameter int CH_BITS = 1,
    parameter int LEN_W   = 24
) (
    input  logic               clkin,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [3+CH_BITS:0] reg_addr,
    input  logic [7:0]         reg_data_in,
    output logic [7:0]         reg_data_out,
    input  logic               reg_oe_falling,
    input  logic               reg_we_rising,
    output logic               loop_enable,
    output logic               irq,
    input  logic               BUS_RDY,
    output logic               BUS_RRQ,
    output logic               BUS_WRQ,
    output logic [23:0]        ROM_ADDR,
    output logic [15:0]        ROM_DATA_OUT,
    output logic               ROM_WORD_ENABLE,
    input  logic [15:0]        ROM_DATA_IN
);

    localparam int NUM_CH = 2 ** CH_BITS;
`ifdef DMA_FILL_EN
    localparam logic c_FILL_EN = 1'b1;
`else
    localparam logic c_FILL_EN = 1'b0;
`endif
    localparam logic [3:0] c_REG_CTRL    = 4'h9;
    localparam logic [3:0] c_REG_FILL_LO = 4'hA;
    localparam logic [3:0] c_REG_FILL_HI = 4'hB;
    localparam logic [3:0] c_REG_STATUS  = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARB   = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

    state_t r_state;
    state_t w_next;

    // Register file (software view) and per-channel active shadows
    logic [7:0]       r_regs [NUM_CH][12];
    logic [23:0]      r_src  [NUM_CH];
    logic [23:0]      r_dst  [NUM_CH];
    logic [LEN_W-1:0] r_len  [NUM_CH];
    logic [4:0]       r_op   [NUM_CH];
    logic [15:0]      r_fill [NUM_CH];
    logic [NUM_CH-1:0] r_busy, r_done, r_abort, r_loop, r_dir, r_word;

    logic [CH_BITS-1:0] r_cur;      // channel owning the current element
    logic [CH_BITS-1:0] r_last;     // last granted channel (round-robin base)
    logic               r_rd_lsb;   // src[0] of the read feeding this write
    logic [7:0]         r_rdata;

    // Register bus decode
    logic [CH_BITS-1:0] w_ch;
    logic [3:0]         w_reg;
    logic               w_wr, w_rd, w_reg_writable;
    logic               w_start, w_abort_req, w_op_ok;
    logic [4:0]         w_op_in;
    logic [23:0]        w_cfg_src, w_cfg_dst, w_cfg_len24;
    logic [LEN_W-1:0]   w_cfg_len;
    logic [7:0]         w_rdata;

    assign w_ch    = reg_addr[3+CH_BITS:4];
    assign w_reg   = reg_addr[3:0];
    assign w_wr    = enable & reg_we_rising;
    assign w_rd    = enable & reg_oe_falling;
    assign w_op_in = reg_data_in[7:3];

    assign w_reg_writable = (w_reg <= c_REG_CTRL) ||
                            (((w_reg == c_REG_FILL_LO) || (w_reg == c_REG_FILL_HI)) && c_FILL_EN);

    assign w_cfg_src   = {r_regs[w_ch][1], r_regs[w_ch][3], r_regs[w_ch][2]};
    assign w_cfg_dst   = {r_regs[w_ch][0], r_regs[w_ch][5], r_regs[w_ch][4]};
    assign w_cfg_len24 = {r_regs[w_ch][8], r_regs[w_ch][7], r_regs[w_ch][6]};
    assign w_cfg_len   = w_cfg_len24[LEN_W-1:0];

    assign w_op_ok     = (w_op_in <= 5'd2) || ((w_op_in == 5'd3) && c_FILL_EN);
    assign w_start     = w_wr && (w_reg == c_REG_CTRL) &&  reg_data_in[0] && !r_busy[w_ch];
    assign w_abort_req = w_wr && (w_reg == c_REG_CTRL) && !reg_data_in[0] &&  r_busy[w_ch];

    always_comb begin
        w_rdata = 8'h00;
        if (w_reg <= c_REG_CTRL) begin
            w_rdata = r_regs[w_ch][w_reg];
        end else if ((w_reg == c_REG_FILL_LO) || (w_reg == c_REG_FILL_HI)) begin
            w_rdata = c_FILL_EN ? r_regs[w_ch][w_reg] : 8'h00;
        end else if (w_reg == c_REG_STATUS) begin
            w_rdata = {6'b0, r_done[w_ch], r_busy[w_ch]};
        end
    end

    // Round-robin pick: first busy channel strictly after r_last, wrapping
    // around so that r_last itself is considered last.
    logic               w_found;
    logic [CH_BITS-1:0] w_pick, w_idx;

    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = r_last;
        for (int i = 1; i <= NUM_CH; i++) begin
            w_idx = r_last + CH_BITS'(i);
            if (!w_found && r_busy[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    // Element datapath for the current channel
    logic [23:0]       w_step, w_src_nxt, w_dst_nxt;
    logic [LEN_W-1:0]  w_len_nxt;
    logic              w_complete;
    logic [NUM_CH-1:0] w_busy_after;
    logic [7:0]        w_byte, w_fill_byte;

    assign w_step     = r_word[r_cur] ? 24'd2 : 24'd1;
    assign w_src_nxt  = r_dir[r_cur] ? (r_src[r_cur] - w_step) : (r_src[r_cur] + w_step);
    assign w_dst_nxt  = r_dir[r_cur] ? (r_dst[r_cur] - w_step) : (r_dst[r_cur] + w_step);
    assign w_len_nxt  = r_len[r_cur] - LEN_W'(r_word[r_cur] ? 2 : 1);
    assign w_complete = (r_state == S_NEXT) &&
                        ((r_len[r_cur] == '0) || r_abort[r_cur]);
    assign w_busy_after = r_busy & ~(w_complete ? (NUM_CH'(1) << r_cur) : '0);

    assign w_byte      = r_rd_lsb ? ROM_DATA_IN[7:0] : ROM_DATA_IN[15:8];
    assign w_fill_byte = r_dst[r_cur][0] ? r_fill[r_cur][15:8] : r_fill[r_cur][7:0];

    always_comb begin
        ROM_DATA_OUT = 16'h0000;
        case (r_op[r_cur])
            5'd0:    ROM_DATA_OUT = r_word[r_cur] ? ROM_DATA_IN : {w_byte, w_byte};
            5'd1:    ROM_DATA_OUT = 16'h0000;
            5'd2:    ROM_DATA_OUT = 16'hFFFF;
            5'd3:    ROM_DATA_OUT = r_word[r_cur] ? r_fill[r_cur] : {w_fill_byte, w_fill_byte};
            default: ROM_DATA_OUT = 16'h0000;
        endcase
    end

    // Engine FSM: state register
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Engine FSM: next state and bus outputs
    always_comb begin
        w_next          = r_state;
        BUS_RRQ         = 1'b0;
        BUS_WRQ         = 1'b0;
        ROM_ADDR        = 24'h000000;
        ROM_WORD_ENABLE = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_busy) w_next = S_ARB;
            end
            S_ARB: begin
                if (!w_found)                 w_next = S_IDLE;
                else if (r_op[w_pick] == 5'd0) w_next = S_READ;
                else                          w_next = S_WRITE;
            end
            S_READ: begin
                BUS_RRQ         = BUS_RDY;
                ROM_ADDR        = r_src[r_cur];
                ROM_WORD_ENABLE = r_word[r_cur];
                if (BUS_RDY) w_next = S_WRITE;
            end
            S_WRITE: begin
                BUS_WRQ         = BUS_RDY;
                ROM_ADDR        = r_dst[r_cur];
                ROM_WORD_ENABLE = r_word[r_cur];
                if (BUS_RDY) w_next = S_NEXT;
            end
            S_NEXT: begin
                w_next = (|w_busy_after) ? S_ARB : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Registers, flags and shadows
    always_ff @(posedge clkin) begin
        if (!reset_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int r = 0; r < 12; r++) r_regs[c][r] <= 8'h00;
                r_src[c]  <= '0;
                r_dst[c]  <= '0;
                r_len[c]  <= '0;
                r_op[c]   <= '0;
                r_fill[c] <= '0;
            end
            r_busy   <= '0;
            r_done   <= '0;
            r_abort  <= '0;
            r_loop   <= '0;
            r_dir    <= '0;
            r_word   <= '0;
            r_cur    <= '0;
            r_last   <= CH_BITS'(NUM_CH - 1);
            r_rd_lsb <= 1'b0;
            r_rdata  <= 8'h00;
        end else begin
            if (w_rd) begin
                r_rdata <= w_rdata;
                if (w_reg == c_REG_STATUS) r_done[w_ch] <= 1'b0;
            end

            if (w_wr && w_reg_writable) begin
                r_regs[w_ch][w_reg] <= reg_data_in;
            end

            if (w_start) begin
                if ((w_cfg_len == '0) || !w_op_ok) begin
                    // Nothing to move: finish on the spot, trig drops at once
                    r_done[w_ch]             <= 1'b1;
                    r_regs[w_ch][c_REG_CTRL] <= {reg_data_in[7:1], 1'b0};
                end else begin
                    r_busy[w_ch]  <= 1'b1;
                    r_done[w_ch]  <= 1'b0;
                    r_abort[w_ch] <= 1'b0;
                    r_src[w_ch]   <= w_cfg_src;
                    r_dst[w_ch]   <= w_cfg_dst;
                    r_len[w_ch]   <= w_cfg_len;
                    r_op[w_ch]    <= w_op_in;
                    r_loop[w_ch]  <= reg_data_in[2];
                    r_dir[w_ch]   <= reg_data_in[1];
                    r_fill[w_ch]  <= {r_regs[w_ch][c_REG_FILL_HI], r_regs[w_ch][c_REG_FILL_LO]};
                    r_word[w_ch]  <= ~w_cfg_src[0] & ~w_cfg_dst[0] & ~w_cfg_len[0];
                end
            end else if (w_abort_req) begin
                r_abort[w_ch] <= 1'b1;
            end

            case (r_state)
                S_ARB: begin
                    if (w_found) begin
                        r_cur  <= w_pick;
                        r_last <= w_pick;
                    end
                end
                S_READ: begin
                    if (BUS_RDY) begin
                        r_src[r_cur] <= w_src_nxt;
                        r_rd_lsb     <= r_src[r_cur][0];
                    end
                end
                S_WRITE: begin
                    if (BUS_RDY) begin
                        r_dst[r_cur] <= w_dst_nxt;
                        r_len[r_cur] <= w_len_nxt;
                    end
                end
                S_NEXT: begin
                    // Placed after the register-bus updates so completion
                    // wins for busy/done; a same-cycle control write to this
                    // channel keeps its written trig bit.
                    if (w_complete) begin
                        r_busy[r_cur]  <= 1'b0;
                        r_done[r_cur]  <= 1'b1;
                        r_abort[r_cur] <= 1'b0;
                        if (!(w_wr && (w_reg == c_REG_CTRL) && (w_ch == r_cur))) begin
                            r_regs[r_cur][c_REG_CTRL][0] <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign reg_data_out = r_rdata;
    assign loop_enable  = |(r_busy & r_loop);
    assign irq          = |r_done;

endmodule
`default_nettype wire
